asconp_iter: RTL and testbench

- Iterating sequencer around the combinational Ascon permutation `asconp`.
- Accepts a 320-bit state and a round count over a valid/ready handshake, then holds the state in a register.
- Drives `asconp` with `round_cnt`, applying UROL rounds per cycle until the count is exhausted, and presents the result on a valid/ready output.
- Sits between the mode controller (init, absorb, squeeze, finalization) and `asconp`. It is the only owner of the permutation state register.

---
 rtl/ascon_pkg.sv | 28 ++
 rtl/asconp.sv | 62 ++++++
 rtl/asconp_iter.sv | 100 ++++++++++
 tb/tb_asconp_iter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared constants and types for the Ascon permutation datapath.
// States: IDLE accept request | RUN apply UROL rounds per cycle | DONE hold result.
package ascon_pkg;

  localparam int UROL          = 1;
  localparam int ROUNDS_A      = 12;
  localparam int ROUNDS_B      = 6;
  localparam int ROUNDS_B_128A = 8;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } iter_state_t;

  function automatic logic rounds_legal(input logic [3:0] r);
    return (r >= 4'd1) && (r <= 4'd12) && ((32'(r) % 32'(UROL)) == 32'd0);
  endfunction

endpackage

// File: rtl/asconp.sv
// Combinational Ascon permutation: UROL rounds starting at remaining count round_cnt.
// The substitution layer uses the 5-bit S-box table applied per bit column.
module asconp
  import ascon_pkg::*;
(
  input  logic [3:0]   round_cnt,
  input  ascon_state_t state_i,
  output ascon_state_t state_o
);

  function automatic logic [4:0] sbox(input logic [4:0] v);
    logic [4:0] r;
    case (v)
      5'd0:  r = 5'h04;  5'd1:  r = 5'h0b;  5'd2:  r = 5'h1f;  5'd3:  r = 5'h14;
      5'd4:  r = 5'h1a;  5'd5:  r = 5'h15;  5'd6:  r = 5'h09;  5'd7:  r = 5'h02;
      5'd8:  r = 5'h1b;  5'd9:  r = 5'h05;  5'd10: r = 5'h08;  5'd11: r = 5'h12;
      5'd12: r = 5'h1d;  5'd13: r = 5'h03;  5'd14: r = 5'h06;  5'd15: r = 5'h1c;
      5'd16: r = 5'h1e;  5'd17: r = 5'h13;  5'd18: r = 5'h07;  5'd19: r = 5'h0e;
      5'd20: r = 5'h00;  5'd21: r = 5'h0d;  5'd22: r = 5'h11;  5'd23: r = 5'h18;
      5'd24: r = 5'h10;  5'd25: r = 5'h0c;  5'd26: r = 5'h01;  5'd27: r = 5'h19;
      5'd28: r = 5'h16;  5'd29: r = 5'h0a;  5'd30: r = 5'h0f;  5'd31: r = 5'h17;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Remaining count c maps to round index 12-c; constant is {~idx, idx}.
  function automatic ascon_state_t round_f(input ascon_state_t s, input logic [3:0] cnt);
    ascon_state_t a;
    ascon_state_t u;
    logic [3:0]   idx;
    idx = 4'd12 - cnt;
    a = s;
    a.x2[7:0] = a.x2[7:0] ^ {~idx, idx};
    u = a;
    for (int b = 0; b < 64; b++) begin
      {u.x0[b], u.x1[b], u.x2[b], u.x3[b], u.x4[b]} =
        sbox({a.x0[b], a.x1[b], a.x2[b], a.x3[b], a.x4[b]});
    end
    u.x0 = u.x0 ^ ror(u.x0, 19) ^ ror(u.x0, 28);
    u.x1 = u.x1 ^ ror(u.x1, 61) ^ ror(u.x1, 39);
    u.x2 = u.x2 ^ ror(u.x2, 1)  ^ ror(u.x2, 6);
    u.x3 = u.x3 ^ ror(u.x3, 10) ^ ror(u.x3, 17);
    u.x4 = u.x4 ^ ror(u.x4, 7)  ^ ror(u.x4, 41);
    return u;
  endfunction

  ascon_state_t st;

  always_comb begin
    st = state_i;
    for (int k = 0; k < UROL; k++) begin
      st = round_f(st, round_cnt - 4'(k));
    end
    state_o = st;
  end

endmodule

// File: rtl/asconp_iter.sv
// Iterating sequencer around asconp; sole owner of the 320-bit permutation state.
// Accepts state + round count, runs UROL rounds per cycle, then holds the result.
module asconp_iter
  import ascon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_rounds,
  input  logic [63:0] in_x0,
  input  logic [63:0] in_x1,
  input  logic [63:0] in_x2,
  input  logic [63:0] in_x3,
  input  logic [63:0] in_x4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_err,
  output logic [63:0] out_x0,
  output logic [63:0] out_x1,
  output logic [63:0] out_x2,
  output logic [63:0] out_x3,
  output logic [63:0] out_x4
);

  localparam logic [3:0] UROL_C = 4'(UROL);

  iter_state_t  fsm_q, fsm_d;
  ascon_state_t state_q, state_d, perm_s;
  logic [3:0]   rnd_q, rnd_d;
  logic         err_q, err_d;

  asconp u_asconp (
    .round_cnt (rnd_q),
    .state_i   (state_q),
    .state_o   (perm_s)
  );

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    err_d   = err_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = {in_x0, in_x1, in_x2, in_x3, in_x4};
          rnd_d   = in_rounds;
          if (in_rounds == 4'd0) begin
            fsm_d = DONE;
            err_d = 1'b0;
          end else if (!rounds_legal(in_rounds)) begin
            fsm_d = DONE;
            err_d = 1'b1;
          end else begin
            fsm_d = RUN;
            err_d = 1'b0;
          end
        end
      end
      RUN: begin
        state_d = perm_s;
        // Saturating decrement keeps the counter from wrapping.
        rnd_d   = (rnd_q >= UROL_C) ? (rnd_q - UROL_C) : 4'd0;
        if (rnd_q <= UROL_C) fsm_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
          err_d = 1'b0;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign out_err   = err_q;
  assign out_x0    = state_q.x0;
  assign out_x1    = state_q.x1;
  assign out_x2    = state_q.x2;
  assign out_x3    = state_q.x3;
  assign out_x4    = state_q.x4;

endmodule

// File: tb/tb_asconp_iter.sv
// Directed bench for asconp_iter; permutation results come from a C-style Ascon round model.
module tb_asconp_iter;
  import ascon_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   in_rounds = 4'd0;
  ascon_state_t in_s = '0;
  logic         in_ready, out_valid, out_err;
  logic [63:0]  out_x0, out_x1, out_x2, out_x3, out_x4;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  asconp_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rounds (in_rounds),
    .in_x0     (in_s.x0),
    .in_x1     (in_s.x1),
    .in_x2     (in_s.x2),
    .in_x3     (in_s.x3),
    .in_x4     (in_s.x4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_err   (out_err),
    .out_x0    (out_x0),
    .out_x1    (out_x1),
    .out_x2    (out_x2),
    .out_x3    (out_x3),
    .out_x4    (out_x4)
  );

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic ascon_state_t model_perm(input ascon_state_t s, input int rounds);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s.x0; x1 = s.x1; x2 = s.x2; x3 = s.x3; x4 = s.x4;
    for (int c = rounds; c >= 1; c--) begin
      x2 ^= 64'((15 - (12 - c)) * 16 + (12 - c));
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      x0 ^= ror(x0, 19) ^ ror(x0, 28);
      x1 ^= ror(x1, 61) ^ ror(x1, 39);
      x2 ^= ror(x2, 1)  ^ ror(x2, 6);
      x3 ^= ror(x3, 10) ^ ror(x3, 17);
      x4 ^= ror(x4, 7)  ^ ror(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic bit is_legal(input int r);
    return (r >= 1) && (r <= 12) && ((r % UROL) == 0);
  endfunction
  function automatic int exp_lat(input int r);
    return is_legal(r) ? r / UROL : 0;
  endfunction
  function automatic logic exp_err(input int r);
    return (r != 0) && !is_legal(r);
  endfunction
  function automatic ascon_state_t exp_state(input ascon_state_t s, input int r);
    return is_legal(r) ? model_perm(s, r) : s;
  endfunction
  function automatic ascon_state_t cur_out();
    return {out_x0, out_x1, out_x2, out_x3, out_x4};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_state(input string tag, input ascon_state_t obs, input ascon_state_t expv);
    chk({tag, "_x0"}, obs.x0, expv.x0);
    chk({tag, "_x1"}, obs.x1, expv.x1);
    chk({tag, "_x2"}, obs.x2, expv.x2);
    chk({tag, "_x3"}, obs.x3, expv.x3);
    chk({tag, "_x4"}, obs.x4, expv.x4);
  endtask

  // Accept one request, scramble inputs afterwards, and check the held result.
  task automatic request(input string tag, input ascon_state_t s, input int r);
    int n;
    in_s = s; in_rounds = 4'(r); in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_s = ~s; in_rounds = 4'(r + 3);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat(r)));
    chk_state(tag, cur_out(), exp_state(s, r));
    chk({tag, "_err"}, 64'(out_err), 64'(exp_err(r)));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_rel_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_rel_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_rel_err"},   64'(out_err), 64'd0);
  endtask

  initial begin
    ascon_state_t zero_s, iv_s, v0_s, bp_exp;
    ascon_state_t exp_q [3];
    int acc_cyc [3];
    int val_cyc [3];
    int na, nv, cyc;
    logic rb;

    zero_s = '0;
    iv_s   = {64'h80400c0600000000, 64'h0, 64'h0, 64'h0, 64'h0};
    v0_s   = {64'h0123456789ABCDEF, 64'h1, 64'h2, 64'h3, 64'h4};

    step(); step();
    rst = 1'b0;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_err",   64'(out_err), 64'd0);
    chk_state("rst_state", cur_out(), zero_s);

    request("zero_rounds", v0_s, 0);
    release_result("zero_rounds");

    request("p12_zero", zero_s, ROUNDS_A);
    release_result("p12_zero");
    request("p12_iv", iv_s, ROUNDS_A);
    release_result("p12_iv");
    request("p6_iv", iv_s, ROUNDS_B);
    release_result("p6_iv");
    request("p6_zero", zero_s, ROUNDS_B);
    release_result("p6_zero");
    request("p8_v0", v0_s, ROUNDS_B_128A);
    release_result("p8_v0");

    request("illegal13", v0_s, 13);
    release_result("illegal13");
    request("rounds7", iv_s, 7);
    release_result("rounds7");
    request("after_illegal", v0_s, ROUNDS_A);
    release_result("after_illegal");

    // Backpressure: result must hold while in_valid pulses are ignored.
    request("bp", iv_s, ROUNDS_B);
    bp_exp = exp_state(iv_s, ROUNDS_B);
    for (int i = 0; i < 20; i++) begin
      in_valid  = i[0];
      in_s      = {64'(i), 64'hDEAD, 64'hBEEF, 64'(i * 7), 64'h55};
      in_rounds = 4'd12;
      step();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_ready", 64'(in_ready), 64'd0);
      chk("bp_x0", out_x0, bp_exp.x0);
      chk("bp_x4", out_x4, bp_exp.x4);
    end
    in_valid = 1'b0;
    release_result("bp");
    step();
    chk("bp_idle_valid", 64'(out_valid), 64'd0);
    chk("bp_idle_ready", 64'(in_ready), 64'd1);

    // Reset mid-RUN.
    in_s = iv_s; in_rounds = 4'd12; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_err",   64'(out_err), 64'd0);
    chk_state("midrst_state", cur_out(), zero_s);
    request("post_rst", zero_s, ROUNDS_B);
    release_result("post_rst");

    // Back-to-back 8-round requests with out_ready held high.
    out_ready = 1'b1; in_rounds = 4'd8; in_valid = 1'b1; in_s = v0_s;
    na = 0; nv = 0; cyc = 0;
    for (int i = 0; i < 80 && nv < 3; i++) begin
      rb = in_ready;
      step();
      cyc++;
      if (rb && na < 3) begin
        acc_cyc[na] = cyc;
        exp_q[na]   = exp_state(in_s, 8);
        na++;
        in_s = {in_s.x1, in_s.x2, in_s.x3, in_s.x4, in_s.x0 ^ 64'(cyc)};
      end
      if (out_valid && nv < 3) begin
        val_cyc[nv] = cyc;
        chk_state("b2b", cur_out(), exp_q[nv]);
        nv++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_results", 64'(nv), 64'd3);
    if (nv == 3) begin
      for (int i = 0; i < 3; i++)
        chk("b2b_lat", 64'(val_cyc[i] - acc_cyc[i]), 64'(exp_lat(8)));
      chk("b2b_space01", 64'(acc_cyc[1] - acc_cyc[0]), 64'(exp_lat(8) + 2));
      chk("b2b_space12", 64'(acc_cyc[2] - acc_cyc[1]), 64'(exp_lat(8) + 2));
    end
    step();
    out_ready = 1'b0;
    chk("end_ready", 64'(in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
